// File: rtl/latch_edge_logger_pkg.sv
// Shared types and defaults for the latch observation path.
package latch_obs_pkg;

   localparam int LATCH_TS_W        = 16;
   localparam int LATCH_SYNC_STAGES = 2;

   // One logged transition: polarity plus the timestamp of the detection cycle.
   typedef struct packed {
      logic                  rise;
      logic [LATCH_TS_W-1:0] ts;
   } edge_evt_t;

endpackage

// File: rtl/latch_edge_logger_if.sv
// Event drain channel: producer drives valid/rise/ts, consumer drives ready.
interface latch_edge_logger_if
   import latch_obs_pkg::*;
#(
   parameter int TS_W = LATCH_TS_W
);
   logic            evt_valid;
   logic            evt_ready;
   logic            evt_rise;
   logic [TS_W-1:0] evt_ts;

   modport master (output evt_valid, output evt_rise, output evt_ts, input evt_ready);
   modport slave  (input evt_valid, input evt_rise, input evt_ts, output evt_ready);
endinterface

// File: rtl/latch_edge_logger_evt_fifo.sv
// Small synchronous event FIFO; head entry is read straight from storage.
module evt_fifo #(
   parameter int W     = 17,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          clr_n,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata,
   output logic          empty,
   output logic [AW:0]   count
);

   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          full;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   // Storage write; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/latch_edge_logger.sv
// Synchronises the latch output, detects transitions and logs them with
// a free-running timestamp into a small FIFO drained over valid/ready.
module latch_edge_logger
   import latch_obs_pkg::*;
#(
   parameter int TS_W        = LATCH_TS_W,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = LATCH_SYNC_STAGES
) (
   input  logic clk,
   input  logic clr_n,
   input  logic q_in,
   input  logic en,
   input  logic ovf_clr,
   output logic overflow,
   latch_edge_logger_if.master evt
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = $clog2(SYNC_STAGES + 2);
   localparam logic [PW-1:0] PRIME_DONE = PW'(SYNC_STAGES + 1);
   localparam logic [AW:0]   CNT_FULL   = (AW+1)'(DEPTH);

   logic [SYNC_STAGES-1:0] sync;
   logic                   q_sync;
   logic                   q_prev;
   logic [PW-1:0]          prime_cnt;
   logic                   primed;
   logic [TS_W-1:0]        ts;
   logic                   edge_det;
   logic                   push;
   logic                   pop;
   logic                   drop;
   logic [TS_W:0]          head;
   logic                   fifo_empty;
   logic [AW:0]            fifo_count;

   assign q_sync   = sync[SYNC_STAGES-1];
   assign primed   = (prime_cnt == PRIME_DONE);
   assign edge_det = q_sync ^ q_prev;
   assign push     = edge_det && en && primed;
   assign pop      = !fifo_empty && evt.evt_ready;
   assign drop     = push && !pop && (fifo_count == CNT_FULL);

   // Synchroniser chain, previous-value tracker and priming counter.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         sync      <= '0;
         q_prev    <= 1'b0;
         prime_cnt <= '0;
      end else begin
         sync   <= {sync[SYNC_STAGES-2:0], q_in};
         q_prev <= q_sync;
         if (prime_cnt != PRIME_DONE) prime_cnt <= prime_cnt + 1'b1;
      end
   end

   // Free-running timestamp, independent of the logging enable.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) ts <= '0;
      else        ts <= ts + 1'b1;
   end

   // Sticky overflow; a drop in the same cycle as a clear keeps it set.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n)       overflow <= 1'b0;
      else if (drop)    overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
   end

   evt_fifo #(
      .W     (TS_W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .clr_n (clr_n),
      .push  (push),
      .pop   (pop),
      .wdata ({q_sync, ts}),
      .rdata (head),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Present the head entry; force zeros while empty so stale storage never leaks.
   always_comb begin
      evt.evt_valid = !fifo_empty;
      evt.evt_rise  = 1'b0;
      evt.evt_ts    = '0;
      if (!fifo_empty) begin
         evt.evt_rise = head[TS_W];
         evt.evt_ts   = head[TS_W-1:0];
      end
   end

endmodule

// File: tb/tb_latch_edge_logger.sv
// Bench for latch_edge_logger: directed scenarios plus random traffic,
// compared every cycle against a sample-history reference model.
module tb_latch_edge_logger;
   import latch_obs_pkg::*;

   localparam int DEPTH = 4;
   localparam int S     = LATCH_SYNC_STAGES;

   logic clk     = 1'b0;
   logic clr_n   = 1'b0;
   logic q_in    = 1'b1;
   logic en      = 1'b1;
   logic ovf_clr = 1'b0;
   logic overflow;

   latch_edge_logger_if #(.TS_W(LATCH_TS_W)) evt();

   latch_edge_logger #(
      .TS_W        (LATCH_TS_W),
      .DEPTH       (DEPTH),
      .SYNC_STAGES (S)
   ) dut (
      .clk      (clk),
      .clr_n    (clr_n),
      .q_in     (q_in),
      .en       (en),
      .ovf_clr  (ovf_clr),
      .overflow (overflow),
      .evt      (evt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: every sampled q_in since reset release is remembered;
   // the synchronised view lags the samples by S edges.
   edge_evt_t m_q[$];
   bit        m_samp[$];
   bit        m_ovf   = 1'b0;
   int        m_edges = 0;
   int        n_pops  = 0;

   function automatic bit samp_at(int j);
      if (j >= 1) return m_samp[j-1];
      return 1'b0;
   endfunction

   always @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         m_q.delete();
         m_samp.delete();
         m_ovf   = 1'b0;
         m_edges = 0;
      end else begin
         bit now_v, prev_v, pushed, popped, dropped;
         edge_evt_t ev;
         now_v   = samp_at(m_edges - S + 1);
         prev_v  = samp_at(m_edges - S);
         pushed  = (now_v != prev_v) && en && (m_edges >= S + 1);
         popped  = (m_q.size() > 0) && evt.evt_ready;
         dropped = 1'b0;
         if (popped) begin
            ev = m_q.pop_front();
            n_pops++;
            $display("[%0t] pop rise=%0d ts=%0d", $time, ev.rise, ev.ts);
         end
         if (pushed) begin
            if (m_q.size() < DEPTH) begin
               ev.rise = now_v;
               ev.ts   = LATCH_TS_W'(m_edges);
               m_q.push_back(ev);
            end else begin
               dropped = 1'b1;
            end
         end
         if (dropped)      m_ovf = 1'b1;
         else if (ovf_clr) m_ovf = 1'b0;
         m_samp.push_back(q_in);
         m_edges++;
      end
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      logic [31:0] e_rise, e_ts;
      e_rise = 0;
      e_ts   = 0;
      if (m_q.size() > 0) begin
         e_rise = 32'(m_q[0].rise);
         e_ts   = 32'(m_q[0].ts);
      end
      check_value("evt_valid", 32'(evt.evt_valid), 32'(m_q.size() > 0));
      check_value("evt_rise", 32'(evt.evt_rise), e_rise);
      check_value("evt_ts", 32'(evt.evt_ts), e_ts);
      check_value("overflow", 32'(overflow), 32'(m_ovf));
   endtask

   // One cycle: check settled outputs, then drive the next inputs.
   task automatic step(input bit q, input bit e, input bit rdy, input bit oc, input bit rn = 1'b1);
      @(negedge clk);
      check_outputs();
      q_in          = q;
      en            = e;
      evt.evt_ready = rdy;
      ovf_clr       = oc;
      clr_n         = rn;
   endtask

   initial begin
      int   pops0;
      int   exp_ts;
      bit   q;
      evt.evt_ready = 1'b1;

      // q_in held high through reset: priming must hide the spurious rise.
      repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      repeat (10) step(1'b1, 1'b1, 1'b1, 1'b0);
      check_value("prime_no_valid", 32'(evt.evt_valid), 0);
      check_value("prime_no_ovf", 32'(overflow), 0);

      // Fall, then rise with a known timestamp.
      step(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (6) step(1'b0, 1'b1, 1'b0, 1'b0);
      check_value("fall_valid", 32'(evt.evt_valid), 1);
      check_value("fall_rise", 32'(evt.evt_rise), 0);
      repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      exp_ts = m_edges + S;
      repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      check_value("rise_valid", 32'(evt.evt_valid), 1);
      check_value("rise_pol", 32'(evt.evt_rise), 1);
      check_value("rise_ts", 32'(evt.evt_ts), 32'(exp_ts));
      repeat (4) step(1'b1, 1'b1, 1'b1, 1'b0);

      // Five toggles with no consumer: four held, fifth dropped.
      q = 1'b1;
      for (int i = 0; i < 5; i++) begin
         q = ~q;
         step(q, 1'b1, 1'b0, 1'b0);
         step(q, 1'b1, 1'b0, 1'b0);
      end
      repeat (4) step(q, 1'b1, 1'b0, 1'b0);
      check_value("full_ovf", 32'(overflow), 1);
      check_value("full_head_fall", 32'(evt.evt_rise), 0);

      // Full FIFO: push and pop in the same cycle, then clear racing a drop.
      q = ~q;
      step(q, 1'b1, 1'b0, 1'b0);
      step(q, 1'b1, 1'b0, 1'b0);
      step(q, 1'b1, 1'b1, 1'b0);
      step(q, 1'b1, 1'b0, 1'b0);
      q = ~q;
      step(q, 1'b1, 1'b0, 1'b0);
      step(q, 1'b1, 1'b0, 1'b0);
      step(q, 1'b1, 1'b0, 1'b1);
      step(q, 1'b1, 1'b0, 1'b0);
      check_value("clr_vs_drop_ovf", 32'(overflow), 1);
      step(q, 1'b1, 1'b0, 1'b1);
      step(q, 1'b1, 1'b0, 1'b0);
      check_value("ovf_cleared", 32'(overflow), 0);

      pops0 = n_pops;
      repeat (8) step(q, 1'b1, 1'b1, 1'b0);
      check_value("drain_pops", 32'(n_pops - pops0), 4);
      check_value("drain_empty", 32'(evt.evt_valid), 0);

      // Disabled logging during three toggles, then one enabled toggle.
      for (int i = 0; i < 3; i++) begin
         q = ~q;
         step(q, 1'b0, 1'b0, 1'b0);
         step(q, 1'b0, 1'b0, 1'b0);
      end
      repeat (3) step(q, 1'b0, 1'b0, 1'b0);
      q = ~q;
      repeat (6) step(q, 1'b1, 1'b0, 1'b0);
      pops0 = n_pops;
      repeat (4) step(q, 1'b1, 1'b1, 1'b0);
      check_value("en_one_event", 32'(n_pops - pops0), 1);

      // Queue three events, pop one, then reset mid-drain.
      for (int i = 0; i < 3; i++) begin
         q = ~q;
         step(q, 1'b1, 1'b0, 1'b0);
         step(q, 1'b1, 1'b0, 1'b0);
      end
      repeat (3) step(q, 1'b1, 1'b0, 1'b0);
      step(q, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      check_outputs();
      clr_n = 1'b0;
      #1;
      check_value("rst_valid", 32'(evt.evt_valid), 0);
      check_value("rst_rise", 32'(evt.evt_rise), 0);
      check_value("rst_ts", 32'(evt.evt_ts), 0);
      check_value("rst_ovf", 32'(overflow), 0);
      repeat (2) step(q, 1'b1, 1'b1, 1'b0, 1'b0);
      repeat (8) step(q, 1'b1, 1'b1, 1'b0);
      check_value("post_rst_idle", 32'(evt.evt_valid), 0);

      // Random traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 2) == 0) q = ~q;
         step(q, $urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 19) == 0, $urandom_range(0, 399) != 0);
      end
      step(q, 1'b1, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
